dma_priority_arbiter: RTL and testbench

- 4-channel DMA request arbiter and service sequencer.
- Selects one unmasked DREQ and runs the HRQ/HLDA bus-hold handshake. Asserts DACK for the granted channel.
- Drives the channel select of the mode register file and reads back the granted channel's 6-bit mode to decide when to release the bus.
- Sits between the DREQ pins, the mode/mask registers and the transfer timing unit.

---
 rtl/dma_priority_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dma_priority_arbiter
//  Description : 4-channel DMA request arbiter and service sequencer.
//                Picks one unmasked DREQ (fixed or rotating priority), runs
//                the HRQ/HLDA bus-hold handshake, drives DACK for the granted
//                channel and releases the bus according to the channel mode.
//  Revision    : 1.0  initial release
// ============================================================================
// The controller-disable pin is named dma_disable because "disable" is a
// reserved word in SystemVerilog.
module dma_priority_arbiter #(
  parameter int NCH    = 4,
  parameter int MODE_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    dreq,
  input  logic [NCH-1:0]    mask,
  input  logic              dma_disable,
  input  logic              rotate_en,
  input  logic              hlda,
  input  logic [MODE_W-1:0] mode_in,
  input  logic              xfer_done,
  input  logic              eop_n,
  input  logic              status_rd,
  output logic [1:0]        ch_sel,
  output logic              hrq,
  output logic [NCH-1:0]    dack,
  output logic              active,
  output logic [NCH-1:0]    tc_status
);

  // Transfer mode encodings found in mode_in[5:4]
  localparam logic [1:0] MODE_DEMAND  = 2'b00;
  localparam logic [1:0] MODE_SINGLE  = 2'b01;
  localparam logic [1:0] MODE_BLOCK   = 2'b10;
  localparam logic [1:0] MODE_CASCADE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HLDA = 2'd1,
    ST_SERVICE   = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [1:0]     ptr, ptr_nxt;
  logic [1:0]     ch_sel_nxt;
  logic           hrq_nxt;
  logic [NCH-1:0] dack_nxt;
  logic           active_nxt;
  logic [NCH-1:0] tc_nxt;
  logic           tc_set;

  logic [NCH-1:0] ereq;
  logic [NCH-1:0] sel_onehot;
  logic [1:0]     mode;
  logic           cur_req;
  logic           cur_mask;
  logic           eop;

  logic           win_found;
  logic [1:0]     win_ch;
  logic [1:0]     win_base;
  logic [1:0]     win_idx;

  logic           svc_release;
  logic           svc_tc;

  // Only the transfer-type field of the mode word matters to this block
  logic           unused_mode_low;
  assign unused_mode_low = ^mode_in[MODE_W-3:0];

  assign ereq       = dreq & ~mask;
  assign sel_onehot = NCH'(1) << ch_sel;
  assign mode       = mode_in[MODE_W-1 -: 2];
  assign cur_req    = dreq[ch_sel];
  assign cur_mask   = mask[ch_sel];
  assign eop        = ~eop_n;

  // Priority search: start at channel 0 (fixed) or at the pointer (rotating)
  always_comb begin
    win_found = 1'b0;
    win_ch    = 2'd0;
    win_idx   = 2'd0;
    win_base  = rotate_en ? ptr : 2'd0;
    for (int i = 0; i < NCH; i++) begin
      win_idx = win_base + 2'(i);
      if (!win_found && ereq[win_idx]) begin
        win_found = 1'b1;
        win_ch    = win_idx;
      end
    end
  end

  // Service release decision; losing HLDA aborts without touching tc_status
  always_comb begin
    svc_release = 1'b0;
    svc_tc      = 1'b0;
    if (!hlda) begin
      svc_release = 1'b1;
    end else if (eop) begin
      svc_release = 1'b1;
      svc_tc      = 1'b1;
    end else if (mode == MODE_CASCADE) begin
      // Cascade ignores xfer_done; it follows the downstream request line
      svc_release = cur_mask | ~cur_req;
    end else if (xfer_done) begin
      case (mode)
        MODE_SINGLE: svc_release = 1'b1;
        MODE_BLOCK:  svc_release = cur_mask;
        MODE_DEMAND: svc_release = cur_mask | ~cur_req;
        default:     svc_release = 1'b0;
      endcase
    end
  end

  // Next-state and registered-output values for the sequencer
  always_comb begin
    state_nxt  = state;
    ch_sel_nxt = ch_sel;
    hrq_nxt    = hrq;
    dack_nxt   = dack;
    active_nxt = active;
    ptr_nxt    = ptr;
    tc_set     = 1'b0;
    case (state)
      ST_IDLE: begin
        hrq_nxt    = 1'b0;
        dack_nxt   = '0;
        active_nxt = 1'b0;
        if (!dma_disable && win_found) begin
          ch_sel_nxt = win_ch;
          hrq_nxt    = 1'b1;
          state_nxt  = ST_WAIT_HLDA;
        end
      end
      ST_WAIT_HLDA: begin
        // ch_sel stays frozen here: no preemption by later requests
        if (!ereq[ch_sel]) begin
          hrq_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end else if (hlda) begin
          dack_nxt   = sel_onehot;
          active_nxt = 1'b1;
          state_nxt  = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (svc_release) begin
          hrq_nxt    = 1'b0;
          dack_nxt   = '0;
          active_nxt = 1'b0;
          tc_set     = svc_tc;
          state_nxt  = ST_RELEASE;
          // Just-served channel becomes lowest priority
          if (rotate_en) begin
            ptr_nxt = ch_sel + 2'd1;
          end
        end
      end
      ST_RELEASE: begin
        hrq_nxt    = 1'b0;
        dack_nxt   = '0;
        active_nxt = 1'b0;
        if (!hlda) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sticky terminal-count flags: a set beats a simultaneous status read
  always_comb begin
    tc_nxt = status_rd ? '0 : tc_status;
    if (tc_set) begin
      tc_nxt = tc_nxt | sel_onehot;
    end
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ch_sel    <= 2'd0;
      hrq       <= 1'b0;
      dack      <= '0;
      active    <= 1'b0;
      ptr       <= 2'd0;
      tc_status <= '0;
    end else begin
      state     <= state_nxt;
      ch_sel    <= ch_sel_nxt;
      hrq       <= hrq_nxt;
      dack      <= dack_nxt;
      active    <= active_nxt;
      ptr       <= ptr_nxt;
      tc_status <= tc_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_priority_arbiter
//  Description : Scoreboard bench for dma_priority_arbiter. Directed scenarios
//                followed by randomized traffic, checked against a phase-level
//                reference model of the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dma_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dreq = '0;
  logic [3:0] mask = '0;
  logic       dma_disable = 1'b0;
  logic       rotate_en = 1'b0;
  logic       hlda = 1'b0;
  logic [5:0] mode_in;
  logic       xfer_done = 1'b0;
  logic       eop_n = 1'b1;
  logic       status_rd = 1'b0;
  logic [1:0] ch_sel;
  logic       hrq;
  logic [3:0] dack;
  logic       active;
  logic [3:0] tc_status;

  // Mode register file seen by the DUT through ch_sel
  logic [5:0] mode_regs [4];
  assign mode_in = mode_regs[ch_sel];

  dma_priority_arbiter #(.NCH(4), .MODE_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dreq       (dreq),
    .mask       (mask),
    .dma_disable(dma_disable),
    .rotate_en  (rotate_en),
    .hlda       (hlda),
    .mode_in    (mode_in),
    .xfer_done  (xfer_done),
    .eop_n      (eop_n),
    .status_rd  (status_rd),
    .ch_sel     (ch_sel),
    .hrq        (hrq),
    .dack       (dack),
    .active     (active),
    .tc_status  (tc_status)
  );

  always #5 clk = ~clk;

  // Stimulus shadow values, applied at the next falling edge
  logic [3:0] d_dreq = '0, d_mask = '0;
  logic       d_dis = 0, d_rot = 0, d_hlda = 0, d_xfer = 0, d_eop_n = 1, d_srd = 0;
  logic       d_echo = 0, d_auto_xfer = 0;
  logic [5:0] d_modes [4];

  // Reference model: phase 0 idle, 1 waiting for hlda, 2 serving, 3 releasing
  int         m_phase, m_ch, m_ptr;
  logic [3:0] m_tc;

  logic [11:0] exp_q [$];
  int n_total = 0;
  int n_bad   = 0;
  int n_cyc   = 0;

  task automatic model_reset();
    m_phase = 0; m_ch = 0; m_ptr = 0; m_tc = '0;
  endtask

  function automatic logic [11:0] pack_exp();
    logic [3:0] dk;
    dk = (m_phase == 2) ? 4'(1 << m_ch) : 4'd0;
    return {2'(m_ch), (m_phase == 1 || m_phase == 2), dk, (m_phase == 2), m_tc};
  endfunction

  task automatic model_step();
    logic [3:0] ereq;
    int  md;
    bit  rel, found;
    int  set_ch;
    ereq = dreq & ~mask;
    set_ch = -1;
    rel = 0;
    case (m_phase)
      0: if (!dma_disable && ereq != 0) begin
           found = 0;
           for (int k = 0; k < 4; k++) begin
             int c;
             c = rotate_en ? (m_ptr + k) % 4 : k;
             if (!found && ereq[c]) begin found = 1; m_ch = c; end
           end
           m_phase = 1;
         end
      1: if (!ereq[m_ch]) m_phase = 0;
         else if (hlda) m_phase = 2;
      2: begin
           md = int'(mode_regs[m_ch][5:4]);
           if (!hlda) rel = 1;
           else if (!eop_n) begin rel = 1; set_ch = m_ch; end
           else if (md == 3) rel = mask[m_ch] || !dreq[m_ch];
           else if (xfer_done) rel = (md == 1) || mask[m_ch] || (md == 0 && !dreq[m_ch]);
           if (rel) begin
             m_phase = 3;
             if (rotate_en) m_ptr = (m_ch + 1) % 4;
           end
         end
      default: if (!hlda) m_phase = 0;
    endcase
    if (status_rd) m_tc = '0;
    if (set_ch >= 0) m_tc[set_ch] = 1'b1;
  endtask

  task automatic check(string nm, logic [11:0] act, logic [11:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got ch=%0d hrq=%b dack=%b active=%b tc=%b ; want ch=%0d hrq=%b dack=%b active=%b tc=%b",
               nm, n_cyc, act[11:10], act[9], act[8:5], act[4], act[3:0],
               exp[11:10], exp[9], exp[8:5], exp[4], exp[3:0]);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next edge
  task automatic step();
    @(negedge clk);
    rst_n       = 1'b1;
    dreq        = d_dreq;
    mask        = d_mask;
    dma_disable = d_dis;
    rotate_en   = d_rot;
    hlda        = d_echo ? hrq : d_hlda;
    xfer_done   = d_auto_xfer ? active : d_xfer;
    eop_n       = d_eop_n;
    status_rd   = d_srd;
    for (int i = 0; i < 4; i++) mode_regs[i] = d_modes[i];
    model_step();
    exp_q.push_back(pack_exp());
    d_xfer = 0; d_eop_n = 1; d_srd = 0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare every predicted response after the rising edge
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      n_cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {ch_sel, hrq, dack, active, tc_status}, e);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin d_modes[i] = 6'b010000; mode_regs[i] = 6'b010000; end
    model_reset();
    #1;
    check("reset_state", {ch_sel, hrq, dack, active, tc_status}, pack_exp());
    repeat (2) @(negedge clk);

    // Fixed priority, single mode: ch1 wins over ch3, then ch3
    d_rot = 0; d_dreq = 4'b1010; d_hlda = 0;
    run(2);
    d_hlda = 1; run(3);
    d_xfer = 1; step();
    d_dreq = 4'b1000; run(1);
    d_hlda = 0; run(2);
    d_hlda = 1; run(2);
    d_xfer = 1; step();
    d_hlda = 0; d_dreq = 0; run(2);

    // Rotating priority with all requests held: ch0, ch1, ch2, ch3, ch0
    d_rot = 1; d_dreq = 4'hf; d_echo = 1; d_auto_xfer = 1;
    run(30);
    d_echo = 0; d_auto_xfer = 0; d_dreq = 0; d_hlda = 0; d_rot = 0;
    run(3);

    // Block mode on ch2: xfer_done keeps the grant, EOP ends it and sets tc
    d_modes[2] = 6'b100000; d_dreq = 4'b0100; d_hlda = 1;
    run(3);
    repeat (3) begin d_xfer = 1; run(2); end
    d_eop_n = 0; step();
    d_hlda = 0; d_dreq = 0; run(2);
    d_srd = 1; step(); run(1);

    // Demand mode on ch0: held request survives transfers; drop then finish
    d_modes[0] = 6'b000000; d_dreq = 4'b0001; d_hlda = 1;
    run(3);
    repeat (3) begin d_xfer = 1; run(2); end
    d_dreq = 0; run(1);
    d_xfer = 1; step();
    d_hlda = 0; run(2);

    // Request withdrawn while waiting for hlda
    d_dreq = 4'b1000; d_hlda = 0; step();
    d_dreq = 0; run(3);

    // Controller disabled: no grant
    d_dis = 1; d_dreq = 4'b0001; run(3);
    d_dis = 0; d_dreq = 0; run(1);

    // Cascade on ch1: masking mid-service releases immediately
    d_modes[1] = 6'b110000; d_dreq = 4'b0010; d_hlda = 1;
    run(4);
    d_mask = 4'b0010; step();
    d_mask = 0; d_hlda = 0; d_dreq = 0; run(2);
    d_dreq = 4'b0010; d_hlda = 1; run(4);
    d_dreq = 0; step();
    d_hlda = 0; run(2);

    // hlda dropped mid-service aborts; then async reset mid-service
    for (int i = 0; i < 4; i++) d_modes[i] = 6'b010000;
    d_dreq = 4'b0010; d_hlda = 1; run(3);
    d_hlda = 0; step(); run(2);
    d_modes[2] = 6'b100000; d_dreq = 4'b0100; d_hlda = 1; run(3);
    d_eop_n = 0; step(); d_hlda = 0; run(2);
    d_hlda = 1; run(3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", {ch_sel, hrq, dack, active, tc_status}, pack_exp());
    d_hlda = 0; d_dreq = 0; run(2);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom % 6 == 0) d_dreq = d_dreq ^ 4'(1 << ($urandom % 4));
      if ($urandom % 40 == 0) d_mask = 4'($urandom) & 4'($urandom);
      d_dis  = ($urandom % 20 == 0);
      if ($urandom % 300 == 0) d_rot = ~d_rot;
      d_echo = ($urandom % 24 != 0);
      d_hlda = 1'($urandom);
      d_xfer = ($urandom % 3 == 0);
      d_eop_n = ($urandom % 14 != 0);
      d_srd  = ($urandom % 10 == 0);
      if ($urandom % 150 == 0) d_modes[$urandom % 4] = 6'($urandom);
      step();
    end
    d_echo = 0; d_hlda = 0; d_dreq = 0; d_mask = 0;
    run(3);
    @(posedge clk); #3;
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending ; want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
